axis_window_expand: RTL

//  Inverse of the window accumulator. Accepts one 128-bit AXI-Stream word and

---
 rtl/axis_window_expand_if.sv | 27 ++
 rtl/axis_window_expand.sv | 88 ++++++++
 2 files changed

// File: rtl/axis_window_expand_if.sv
`default_nettype none
// ============================================================================
// Module : axis_window_expand_if
// Brief  : Stream and config bundle for the window expander (slave = DUT side).
// Rev    : 1.0  initial release
// ============================================================================
interface axis_window_expand_if;
    logic [7:0]   cfg;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;

    modport slave (
        input  cfg, s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output cfg, s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface
`default_nettype wire

// File: rtl/axis_window_expand.sv
`default_nettype none
// ============================================================================
// Module : axis_window_expand
// Brief  : Replays one 128-bit word as a window of max(cfg,1) beats; beats after
//          the first keep only bits [127:66], so OR-ing the window restores it.
// Rev    : 1.0  initial release
// ============================================================================
module axis_window_expand (
    input  wire logic           aclk,
    input  wire logic           areset,
    axis_window_expand_if.slave bus
);
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]   r_state;
    logic [0:0]   w_next_state;
    logic [127:0] r_word;
    logic [7:0]   r_len;
    logic [7:0]   r_cnt;

    logic         w_last;
    logic         w_m_valid;
    logic         w_beat_done;
    logic         w_s_ready;
    logic         w_load;
    logic [7:0]   w_cfg_len;

    assign w_last      = (r_cnt == (r_len - 8'd1));
    assign w_m_valid   = (r_state == c_RUN);
    assign w_beat_done = w_m_valid & bus.m_axis_tready;
    // Accepting on the final handshake lets back-to-back windows run without bubbles.
    assign w_s_ready   = (r_state == c_IDLE) | (w_beat_done & w_last);
    assign w_load      = bus.s_axis_tvalid & w_s_ready;
    assign w_cfg_len   = (bus.cfg == 8'd0) ? 8'd1 : bus.cfg;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.s_axis_tvalid) begin
                    w_next_state = c_RUN;
                end
            end
            c_RUN: begin
                if (w_beat_done && w_last && !bus.s_axis_tvalid) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        bus.s_axis_tready = w_s_ready;
        bus.m_axis_tvalid = 1'b0;
        bus.m_axis_tdata  = 128'd0;
        bus.m_axis_tlast  = 1'b0;
        if (r_state == c_RUN) begin
            bus.m_axis_tvalid = 1'b1;
            bus.m_axis_tdata  = (r_cnt == 8'd0) ? r_word : {r_word[127:66], 66'd0};
            bus.m_axis_tlast  = w_last;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_word <= 128'd0;
            r_len  <= 8'd1;
            r_cnt  <= 8'd0;
        end else if (w_load) begin
            r_word <= bus.s_axis_tdata;
            r_len  <= w_cfg_len;
            r_cnt  <= 8'd0;
        end else if (w_beat_done && !w_last) begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end
endmodule
`default_nettype wire
